imap_rd_seq: RTL

- Read sequencer placed directly downstream of the input feature map buffer. It generates the buffer's read address and read enable, and feeds the MAC array.
- For one 3x3 convolution pass (padding 1, stride 1 or 2) it walks every output pixel and every kernel tap. In-bounds taps read one 32-byte word from the buffer; padding taps get zeros.
- Results leave as a valid/ready stream with kernel-tap and end-of-pass markers.
- A 2-entry skid FIFO absorbs the one-cycle SRAM read latency under MAC backpressure.

---
 rtl/imap_rd_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/imap_rd_seq.sv
// Read sequencer for the input feature map buffer: walks one 3x3 (pad 1) convolution
// pass, issues buffer reads for in-bounds taps and streams tap words to the MAC array.
module imap_rd_seq #(
  parameter int ARRAY_NUM = 32,
  parameter int DIM_W     = 6,
  parameter int AW        = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_W-1:0]       cfg_h,
  input  logic [DIM_W-1:0]       cfg_w,
  input  logic                   cfg_stride2,
  input  logic                   cfg_bank,
  output logic [31:0]            imap_raddr,
  output logic                   imap_ren,
  input  logic [ARRAY_NUM*8-1:0] imap_rdata,
  output logic                   mac_valid,
  input  logic                   mac_ready,
  output logic [ARRAY_NUM*8-1:0] mac_data,
  output logic                   mac_last_k,
  output logic                   mac_last,
  output logic                   busy,
  output logic                   done
);

  localparam int DW = ARRAY_NUM * 8;
  localparam int XW = DIM_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last_k;
    logic          last;
  } beat_t;

  state_t             r_state;
  logic [DIM_W-1:0]   r_h, r_w;
  logic               r_s2, r_bank;
  logic [1:0]         r_kx, r_ky;
  logic [DIM_W-1:0]   r_ox, r_oy;
  logic [31:0]        r_raddr;
  logic               r_s1_v, r_s1_pad, r_s1_lk, r_s1_last;
  beat_t              r_mem [2];
  logic               r_wptr, r_rptr;
  logic [1:0]         r_cnt;
  logic               r_busy, r_done;

  logic [DIM_W-1:0]   w_oh_last, w_ow_last;
  logic [XW-1:0]      w_oy_s, w_ox_s, w_iy, w_ix;
  logic               w_inb, w_issue, w_ren, w_pop, w_push, w_lk, w_last, w_drained;
  logic [2:0]         w_occ;
  logic [AW-1:0]      w_pix;
  logic [31:0]        w_addr;
  beat_t              w_word;

  assign w_oh_last = (r_h - DIM_W'(1)) >> r_s2;
  assign w_ow_last = (r_w - DIM_W'(1)) >> r_s2;

  // Input coordinates are two's complement; only -1 can go negative, so the sign bit flags top/left pad.
  assign w_oy_s = r_s2 ? {1'b0, r_oy, 1'b0} : {2'b00, r_oy};
  assign w_ox_s = r_s2 ? {1'b0, r_ox, 1'b0} : {2'b00, r_ox};
  assign w_iy   = w_oy_s + XW'(r_ky) - XW'(1);
  assign w_ix   = w_ox_s + XW'(r_kx) - XW'(1);
  assign w_inb  = !w_iy[XW-1] && (w_iy[XW-2:0] < {1'b0, r_h}) &&
                  !w_ix[XW-1] && (w_ix[XW-2:0] < {1'b0, r_w});

  assign w_pix  = AW'(w_iy[DIM_W-1:0]) * AW'(r_w) + AW'(w_ix[DIM_W-1:0]);
  assign w_addr = {{(31-AW){1'b0}}, r_bank, w_pix};

  // Issue only when the word can land in the FIFO even if nothing pops afterwards.
  assign w_pop   = mac_valid & mac_ready;
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_s1_v};
  assign w_issue = (r_state == S_RUN) && (w_occ < 3'd2 + {2'b00, w_pop});
  assign w_ren   = w_issue & w_inb;

  assign w_lk   = (r_kx == 2'd2) && (r_ky == 2'd2);
  assign w_last = w_lk && (r_ox == w_ow_last) && (r_oy == w_oh_last);

  assign w_push    = r_s1_v;
  assign w_word    = '{data: (r_s1_pad ? '0 : imap_rdata), last_k: r_s1_lk, last: r_s1_last};
  assign w_drained = !r_s1_v && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));

  assign imap_ren   = w_ren;
  assign imap_raddr = w_ren ? w_addr : r_raddr;
  assign mac_valid  = (r_cnt != 2'd0);
  assign mac_data   = mac_valid ? r_mem[r_rptr].data : '0;
  assign mac_last_k = mac_valid & r_mem[r_rptr].last_k;
  assign mac_last   = mac_valid & r_mem[r_rptr].last;
  assign busy       = r_busy;
  assign done       = r_done;

  // NOTE: FIFO storage has no reset; occupancy is reset and gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_h       <= '0;
      r_w       <= '0;
      r_s2      <= 1'b0;
      r_bank    <= 1'b0;
      r_kx      <= '0;
      r_ky      <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_raddr   <= '0;
      r_s1_v    <= 1'b0;
      r_s1_pad  <= 1'b0;
      r_s1_lk   <= 1'b0;
      r_s1_last <= 1'b0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_s1_v    <= w_issue;
      r_s1_pad  <= !w_inb;
      r_s1_lk   <= w_lk;
      r_s1_last <= w_last;
      if (w_ren)  r_raddr <= w_addr;
      if (w_push) r_wptr  <= ~r_wptr;
      if (w_pop)  r_rptr  <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_h    <= cfg_h;
            r_w    <= cfg_w;
            r_s2   <= cfg_stride2;
            r_bank <= cfg_bank;
            r_kx   <= '0;
            r_ky   <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_busy <= 1'b1;
            r_state <= (cfg_h == '0 || cfg_w == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (r_kx != 2'd2) begin
              r_kx <= r_kx + 2'd1;
            end else begin
              r_kx <= '0;
              if (r_ky != 2'd2) begin
                r_ky <= r_ky + 2'd1;
              end else begin
                r_ky <= '0;
                if (r_ox != w_ow_last) begin
                  r_ox <= r_ox + DIM_W'(1);
                end else begin
                  r_ox <= '0;
                  r_oy <= r_oy + DIM_W'(1);
                end
              end
            end
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
